// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit.
// Holds the FSM state enum, the access size enum, the registered bus opcode
// constants and two small request-decode helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Operation latched at accept time; NONE marks a rejected request.
  localparam logic [1:0] BUS_OP_NONE  = 2'b00;
  localparam logic [1:0] BUS_OP_READ  = 2'b01;
  localparam logic [1:0] BUS_OP_WRITE = 2'b10;

  // A dword access only exists on a 64-bit bus.
  function automatic logic size_legal(input size_e sz, input int data_w);
    return !(sz == SZ_DWORD && data_w != 64);
  endfunction

  // True when addr mod 2^size is non-zero.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_e sz);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and bus signal bundle for mem_access_unit.
// slave  : the unit's view (takes CPU requests, drives the avm bus).
// master : the environment's view (issues requests, acts as bus slave).
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [31:0]       avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [NB-1:0]     avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

endinterface

// File: rtl/byte_lane_swap.sv
// Maps CPU byte lanes to bus byte lanes (and back; the mapping is its own
// inverse). SWAP_BYTES=1 sends lane i to lane NB-1-i, SWAP_BYTES=0 passes through.
// Ports: din (DATA_W) in, dout (DATA_W) out. Pure wiring.
module byte_lane_swap #(
  parameter int DATA_W     = 32,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int NB = DATA_W / 8;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    if (SWAP_BYTES) begin : g_swap
      assign dout[8*(NB-1-i) +: 8] = din[8*i +: 8];
    end else begin : g_ident
      assign dout[8*i +: 8] = din[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store to Avalon-MM bridge, one outstanding access at a time.
// Ports: clk, reset_n (synchronous, active low), bus (mem_access_unit_if.slave):
//   req_*  CPU request handshake, rsp_* one-cycle completion pulse,
//   avm_*  bus master side with waitrequest stall.
// Misaligned or illegal-size requests skip the bus and answer with rsp_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_access_unit_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  size_e             size_q;
  logic              uns_q, err_q;
  logic [OFF_W-1:0]  off_q;
  logic [31:0]       addr_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wd_q, rdata_q;

  size_e             req_size;
  logic [OFF_W-1:0]  req_off;
  logic              req_err, accept;
  logic [NB-1:0]     lane_bits, cpu_be, bus_be;
  logic [DATA_W-1:0] cpu_wd, bus_wd;
  logic [DATA_W-1:0] cpu_rd, rd_shift, rd_mask, ld_data;
  logic              rd_sign;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  // Request decode: lane mask and shifted store data in CPU lane order.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    bus_be    = '0;
    req_size  = size_e'(bus.req_size);
    req_off   = bus.req_addr[OFF_W-1:0];
    req_err   = !size_legal(req_size, DATA_W) || is_misaligned(bus.req_addr[2:0], req_size);
    case (req_size)
      SZ_BYTE: lane_bits = NB'(1);
      SZ_HALF: lane_bits = NB'(3);
      SZ_WORD: lane_bits = NB'(15);
      default: lane_bits = '1;
    endcase
    cpu_be = lane_bits << req_off;
    cpu_wd = bus.req_wdata << {req_off, 3'b000};
    // Unselected lanes carry zeros rather than leftover high store bits.
    for (int i = 0; i < NB; i++) begin
      if (!cpu_be[i]) cpu_wd[8*i +: 8] = 8'h00;
    end
    for (int i = 0; i < NB; i++) begin
      bus_be[SWAP_BYTES ? NB-1-i : i] = cpu_be[i];
    end
  end

  byte_lane_swap #(.DATA_W(DATA_W), .SWAP_BYTES(SWAP_BYTES)) u_wr_swap (
    .din  (cpu_wd),
    .dout (bus_wd)
  );

  byte_lane_swap #(.DATA_W(DATA_W), .SWAP_BYTES(SWAP_BYTES)) u_rd_swap (
    .din  (bus.avm_readdata),
    .dout (cpu_rd)
  );

  // Load extraction: right-justify, mask to size, then sign- or zero-extend.
  always_comb begin
    rd_shift = cpu_rd >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: begin rd_mask = DATA_W'(8'hFF);         rd_sign = rd_shift[7];  end
      SZ_HALF: begin rd_mask = DATA_W'(16'hFFFF);      rd_sign = rd_shift[15]; end
      SZ_WORD: begin rd_mask = DATA_W'(32'hFFFF_FFFF); rd_sign = rd_shift[31]; end
      default: begin rd_mask = '1;                     rd_sign = 1'b0;         end
    endcase
    ld_data = rd_shift & rd_mask;
    if (!uns_q && rd_sign) ld_data = ld_data | ~rd_mask;
  end

  // NOTE: reset is synchronous (sampled on the clock edge), so it sits inside the plain posedge block.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_err ? ST_RESP : ST_BUS;
      ST_BUS:  if (!bus.avm_waitrequest) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus-facing values are latched at accept and held until the next accept,
  // which keeps them stable for the whole waitrequest stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q    <= BUS_OP_NONE;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_err ? BUS_OP_NONE : (bus.req_store ? BUS_OP_WRITE : BUS_OP_READ);
      size_q  <= req_size;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_err;
      off_q   <= req_off;
      addr_q  <= {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
      be_q    <= req_err ? '0 : bus_be;
      wd_q    <= (req_err || !bus.req_store) ? '0 : bus_wd;
      rdata_q <= '0;
    end else if (state_q == ST_BUS && !bus.avm_waitrequest && op_q == BUS_OP_READ) begin
      rdata_q <= ld_data;
    end
  end

  assign bus.req_ready      = (state_q == ST_IDLE);
  assign bus.rsp_valid      = (state_q == ST_RESP);
  assign bus.rsp_err        = (state_q == ST_RESP) && err_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.avm_read       = (state_q == ST_BUS) && (op_q == BUS_OP_READ);
  assign bus.avm_write      = (state_q == ST_BUS) && (op_q == BUS_OP_WRITE);
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_writedata  = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_W=32, SWAP_BYTES=1).
// The driver pushes expected bus cycles and responses into queues; two
// monitors pop and compare whenever the DUT strobes the bus or pulses rsp_valid.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DATA_W)) mif();

  mem_access_unit #(.DATA_W(DATA_W), .SWAP_BYTES(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif)
  );

  typedef struct {
    string       name;
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_bus;
    int          waits;
    bit          has_bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_strobes;
    bit          intrude;
    bit          reset_mid;
  } vec_t;

  typedef struct {
    string       name;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          strobes;
  } bus_item_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_item_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bus_item_t bus_q[$];
  rsp_item_t rsp_q[$];

  // Bus slave model: fixed read data, waitrequest high for wait_cycles cycles.
  logic [31:0] bus_rdata = 32'h0;
  int wait_cycles = 0;
  int wait_cnt = 0;
  assign mif.avm_readdata    = bus_rdata;
  assign mif.avm_waitrequest = (mif.avm_read || mif.avm_write) && (wait_cnt < wait_cycles);
  always @(posedge clk) begin
    if (!(mif.avm_read || mif.avm_write)) wait_cnt <= 0;
    else if (mif.avm_waitrequest)         wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: first strobe cycle of a transaction is compared against the
  // queue, later cycles must hold the same address/byteenable/writedata.
  bus_item_t cur_bus;
  bit        bus_active = 1'b0;
  int        strobe_cnt = 0;
  logic [67:0] bus_snap;
  always @(negedge clk) begin
    if (mif.avm_read || mif.avm_write) begin
      if (!bus_active) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_cycle: got strobe at addr 0x%0h, expected no bus activity", mif.avm_address);
          cur_bus.name = "unexpected";
          cur_bus.strobes = -1;
        end else begin
          cur_bus = bus_q.pop_front();
          check({cur_bus.name, ".one_strobe"}, mif.avm_read ^ mif.avm_write, 1);
          check({cur_bus.name, ".write"}, mif.avm_write, cur_bus.is_write);
          check({cur_bus.name, ".address"}, mif.avm_address, cur_bus.addr);
          check({cur_bus.name, ".byteenable"}, mif.avm_byteenable, cur_bus.be);
          if (cur_bus.is_write) check({cur_bus.name, ".writedata"}, mif.avm_writedata, cur_bus.wd);
        end
        bus_snap   = {mif.avm_address, mif.avm_byteenable, mif.avm_writedata};
        strobe_cnt = 1;
        bus_active = 1'b1;
      end else begin
        strobe_cnt++;
        check({cur_bus.name, ".stable"}, {mif.avm_address, mif.avm_byteenable, mif.avm_writedata}, bus_snap);
      end
    end else if (bus_active) begin
      check({cur_bus.name, ".strobe_cycles"}, strobe_cnt, cur_bus.strobes);
      bus_active = 1'b0;
    end
  end

  // Response monitor.
  bit prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (mif.rsp_valid) begin
      check("rsp_single_cycle", prev_rsp, 0);
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%0h, expected no response", mif.rsp_rdata);
      end else begin
        rsp_item_t r;
        r = rsp_q.pop_front();
        check({r.name, ".rdata"}, mif.rsp_rdata, r.rdata);
        check({r.name, ".err"}, mif.rsp_err, r.err);
        check({r.name, ".latency"}, cyc - r.acc, r.lat);
      end
    end
    prev_rsp = mif.rsp_valid;
  end

  function automatic vec_t mk(input string name, input logic store, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rbus, input int waits, input bit has_bus,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input logic eerr, input int elat);
    vec_t v;
    v.name = name; v.store = store; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.rdata_bus = rbus; v.waits = waits;
    v.has_bus = has_bus; v.exp_addr = eaddr; v.exp_be = ebe; v.exp_wd = ewd;
    v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat;
    v.exp_strobes = waits + 1; v.intrude = 1'b0; v.reset_mid = 1'b0;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    int n;
    @(negedge clk);
    bus_rdata   = v.rdata_bus;
    wait_cycles = v.waits;
    if (v.has_bus) begin
      bus_item_t b;
      b.name = v.name; b.is_write = v.store; b.addr = v.exp_addr;
      b.be = v.exp_be; b.wd = v.exp_wd; b.strobes = v.exp_strobes;
      bus_q.push_back(b);
    end
    mif.req_store    = v.store;
    mif.req_size     = v.size;
    mif.req_unsigned = v.uns;
    mif.req_addr     = v.addr;
    mif.req_wdata    = v.wdata;
    mif.req_valid    = 1'b1;
    n = 0;
    while (!mif.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL %s.accept_timeout: got req_ready 0 for 20 cycles, expected 1", v.name);
      mif.req_valid = 1'b0;
      return;
    end
    if (!v.reset_mid) begin
      rsp_item_t r;
      r.name = v.name; r.rdata = v.exp_rdata; r.err = v.exp_err;
      r.lat = v.exp_lat; r.acc = cyc;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    if (v.intrude) begin
      // A second request presented while the first is on the bus must be ignored.
      mif.req_store = 1'b1;
      mif.req_addr  = 32'h0000_5000;
      mif.req_wdata = 32'hCAFE_F00D;
      check({v.name, ".ready_in_bus"}, mif.req_ready, 0);
      @(negedge clk);
    end
    mif.req_valid = 1'b0;
    if (v.reset_mid) begin
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check({v.name, ".read_after_reset"}, mif.avm_read, 0);
      check({v.name, ".write_after_reset"}, mif.avm_write, 0);
      check({v.name, ".rsp_valid_in_reset"}, mif.rsp_valid, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check({v.name, ".ready_after_release"}, mif.req_ready, 1);
      repeat (6) @(negedge clk);
      return;
    end
    n = 0;
    while ((rsp_q.size() != 0 || bus_active) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL %s.rsp_timeout: got no response in 50 cycles, expected one", v.name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;

    mif.req_valid    = 1'b0;
    mif.req_store    = 1'b0;
    mif.req_size     = 2'd0;
    mif.req_unsigned = 1'b0;
    mif.req_addr     = 32'h0;
    mif.req_wdata    = 32'h0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.req_ready", mif.req_ready, 1);
    check("reset.rsp_valid", mif.rsp_valid, 0);
    check("reset.rsp_err", mif.rsp_err, 0);
    check("reset.rsp_rdata", mif.rsp_rdata, 0);
    check("reset.avm_read", mif.avm_read, 0);
    check("reset.avm_write", mif.avm_write, 0);
    check("reset.avm_address", mif.avm_address, 0);
    check("reset.avm_byteenable", mif.avm_byteenable, 0);
    check("reset.avm_writedata", mif.avm_writedata, 0);
    reset_n = 1'b1;

    //              name              st sz un addr          wdata         rdata_bus     w  bus eaddr         ebe      ewd           erd           er lat
    vecs.push_back(mk("sw_aligned",    1, 2, 0, 32'h0000_1000, 32'h1122_3344, 32'h0,         0, 1, 32'h0000_1000, 4'b1111, 32'h4433_2211, 32'h0,         0, 2));
    vecs.push_back(mk("sb_off3",       1, 0, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0,         0, 1, 32'h0000_1000, 4'b0001, 32'h0000_00AB, 32'h0,         0, 2));
    vecs.push_back(mk("lb_off2",       0, 0, 0, 32'h0000_1002, 32'h0,         32'h4433_8011, 0, 1, 32'h0000_1000, 4'b0010, 32'h0,         32'hFFFF_FF80, 0, 2));
    vecs.push_back(mk("lbu_off2",      0, 0, 1, 32'h0000_1002, 32'h0,         32'h4433_8011, 0, 1, 32'h0000_1000, 4'b0010, 32'h0,         32'h0000_0080, 0, 2));
    vecs.push_back(mk("lh_misaligned", 0, 1, 0, 32'h0000_1001, 32'h0,         32'h4433_8011, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1));
    v = mk("lw_wait3",                 0, 2, 0, 32'h0000_2004, 32'h0,         32'hDDCC_BBAA, 3, 1, 32'h0000_2004, 4'b1111, 32'h0,         32'hAABB_CCDD, 0, 5);
    v.intrude = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mk("lh_off2",       0, 1, 0, 32'h0000_2006, 32'h0,         32'h5566_0080, 0, 1, 32'h0000_2004, 4'b0011, 32'h0,         32'hFFFF_8000, 0, 2));
    vecs.push_back(mk("lhu_off2",      0, 1, 1, 32'h0000_2006, 32'h0,         32'h5566_0080, 0, 1, 32'h0000_2004, 4'b0011, 32'h0,         32'h0000_8000, 0, 2));
    vecs.push_back(mk("sh_wait1",      1, 1, 0, 32'h0000_3002, 32'h0000_BEEF, 32'h0,         1, 1, 32'h0000_3000, 4'b0011, 32'h0000_EFBE, 32'h0,         0, 3));
    vecs.push_back(mk("sb_upper_junk", 1, 0, 0, 32'h0000_1001, 32'hFFFF_FF5A, 32'h0,         0, 1, 32'h0000_1000, 4'b0100, 32'h005A_0000, 32'h0,         0, 2));
    vecs.push_back(mk("sw_misaligned", 1, 2, 0, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1));
    vecs.push_back(mk("ld_illegal",    0, 3, 0, 32'h0000_1000, 32'h0,         32'h1234_5678, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 1));
    v = mk("lw_reset_in_bus",          0, 2, 0, 32'h0000_4000, 32'h0,         32'h1234_5678, 6, 1, 32'h0000_4000, 4'b1111, 32'h0,         32'h0,         0, 0);
    v.reset_mid = 1'b1;
    v.exp_strobes = 2;
    vecs.push_back(v);
    vecs.push_back(mk("lbu_after_rst", 0, 0, 1, 32'h0000_1000, 32'h0,         32'h4433_8011, 0, 1, 32'h0000_1000, 4'b1000, 32'h0,         32'h0000_0044, 0, 2));

    foreach (vecs[i]) issue(vecs[i]);

    repeat (4) @(negedge clk);
    check("end.bus_queue_empty", bus_q.size(), 0);
    check("end.rsp_queue_empty", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, bus/data width in bits; legal values are 32 and 64; NB = DATA_W/8 byte lanes.
REQ-002 Parameter SWAP_BYTES, default 1; when 1, CPU byte lane i maps to bus lane NB-1-i; when 0, the mapping is identity.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_store  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64).
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-justified.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  load result, extended to full width; 0 for stores.
REQ-014 rsp_err  out  1  misaligned or illegal-size request; qualified by rsp_valid.
REQ-015 avm_address  out  32  req_addr aligned down to NB.
REQ-016 avm_read / avm_write  out  1 each  bus strobes.
REQ-017 avm_byteenable  out  NB  bus-order lane mask.
REQ-018 avm_writedata  out  DATA_W  bus-order write data.
REQ-019 avm_readdata  in  DATA_W  bus-order read data.
REQ-020 avm_waitrequest  in  1  slave stall.

Function
REQ-021 FSM states: IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-022 IDLE: a request is accepted on req_valid && req_ready; the unit registers all req_* fields.
REQ-023 Accepted request, aligned and legal: IDLE -> BUS; accepted request, misaligned (addr mod 2^size != 0) or illegal size: IDLE -> RESP with rsp_err = 1 and no bus strobe.
REQ-024 BUS: exactly one of avm_read / avm_write is high; address, byteenable and writedata are constant while avm_waitrequest = 1.
REQ-025 BUS completes on the first cycle with avm_waitrequest = 0; on a load the unit captures avm_readdata in that cycle; BUS -> RESP.
REQ-026 RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE; avm strobes are low in RESP and IDLE.
REQ-027 Latency with zero wait states: accept at T, strobe at T+1, rsp_valid at T+2; each wait cycle adds one.
REQ-028 Byteenable: (2^(2^size)-1) << (addr mod NB) in CPU order, then lane-mapped per SWAP_BYTES.
REQ-029 Write data: req_wdata << 8*(addr mod NB), then lane-mapped; unselected lanes are don't-care but driven 0.
REQ-030 Load data: lane-map readdata, shift right by 8*(addr mod NB), mask to the size, and sign- or zero-extend to DATA_W.
REQ-031 req_valid in BUS or RESP is ignored (req_ready = 0); no request is queued.

Reset
REQ-032 While reset_n = 0 at a clock edge: state = IDLE, avm_read = avm_write = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, avm_address / byteenable / writedata = 0.
REQ-033 Reset asserted in BUS abandons the transaction with no rsp_valid; req_ready = 1 on the first cycle after reset_n rises.

Structure
REQ-034 Package mem_access_pkg holds the fsm state enum, the size enum (SZ_BYTE..SZ_DWORD) and the bus opcode constants.
REQ-035 Sub-module byte_lane_swap, parametrised on DATA_W and SWAP_BYTES, is instantiated twice: once on the write path and once on the read path.

Verification (DATA_W = 32, SWAP_BYTES = 1)
REQ-036 SW addr 0x1000, wdata 0x11223344, waitrequest 0 -> avm_writedata 0x44332211, byteenable 4'b1111, rsp_valid at T+2, rsp_err = 0.
REQ-037 SB addr 0x1003, wdata 0x000000AB -> byteenable 4'b0001, avm_writedata[7:0] = 0xAB, avm_address 0x1000.
REQ-038 LB / LBU addr 0x1002 with readdata 0x44338011 -> rsp_rdata 0xFFFFFF80 / 0x00000080.
REQ-039 LH addr 0x1001 -> no avm strobe; rsp_valid at T+1 with rsp_err = 1.
REQ-040 LW with waitrequest held high for 3 cycles -> avm signals constant for 4 cycles; rsp_valid at T+5; req_valid pulsed during BUS is not accepted.
REQ-041 reset_n low for one cycle during BUS -> strobes low next cycle; no rsp_valid; req_ready = 1 after reset releases.
